// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// Load/store initiator for the data memory port: splits misaligned accesses into
// two aligned word transfers over req/gnt/rvalid and extends returned load data.
module load_store_unit #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [2:0]          Funct3,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic                req_ready,
    output logic                stall,
    output logic                done,
    output logic [DATA_W-1:0]   rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [3:0]          mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int WA_W = ADDR_W - 2;

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    state_t state, state_n;

    logic                accept;
    logic [7:0]          in_mask;
    logic [2*DATA_W-1:0] in_wsh;

    logic [2:0]          op_f3;
    logic [1:0]          op_off;
    logic [3:0]          op_be1;
    logic [DATA_W-1:0]   op_wsh_hi;
    logic [DATA_W-1:0]   op_word0;
    logic                op_split;

    logic                n_req, n_we, n_done;
    logic [WA_W-1:0]     n_addr;
    logic [3:0]          n_be;
    logic [DATA_W-1:0]   n_wdata, n_rdata;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            default: return 8'h0F;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] assemble(input logic [DATA_W-1:0] w1,
                                                   input logic [DATA_W-1:0] w0,
                                                   input logic [1:0]        off);
        return DATA_W'({w1, w0} >> {off, 3'b000});
    endfunction

    function automatic logic [DATA_W-1:0] extend_load(input logic [2:0]        f3,
                                                      input logic [DATA_W-1:0] raw);
        logic signed [7:0]        sb;
        logic signed [15:0]       sh;
        logic signed [DATA_W-1:0] res;
        sb = raw[7:0];
        sh = raw[15:0];
        case (f3)
            3'b000:  res = sb;
            3'b001:  res = sh;
            3'b100:  res = {{(DATA_W-8){1'b0}}, raw[7:0]};
            3'b101:  res = {{(DATA_W-16){1'b0}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    assign accept    = (state == IDLE) && req_valid && (MemRead || MemWrite);
    assign in_mask   = size_mask(Funct3[1:0]) << addr[1:0];
    assign in_wsh    = {{DATA_W{1'b0}}, wdata} << {addr[1:0], 3'b000};
    assign op_split  = |op_be1;

    assign req_ready = (state == IDLE);
    assign stall     = accept || ((state != IDLE) && (state != RESP));

    // Control state and registered memory-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            rdata     <= '0;
        end else begin
            state     <= state_n;
            mem_req   <= n_req;
            mem_we    <= n_we;
            mem_addr  <= n_addr;
            mem_be    <= n_be;
            mem_wdata <= n_wdata;
            done      <= n_done;
            rdata     <= n_rdata;
        end
    end

    // Operation latches; only meaningful while a transaction is in flight
    always_ff @(posedge clk) begin
        if (accept) begin
            op_f3     <= Funct3;
            op_off    <= addr[1:0];
            op_be1    <= in_mask[7:4];
            op_wsh_hi <= in_wsh[2*DATA_W-1:DATA_W];
        end
        if ((state == WAIT0) && mem_rvalid)
            op_word0 <= mem_rdata;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (accept) state_n = REQ0;
            REQ0:  if (mem_gnt) state_n = !mem_we ? WAIT0 : (op_split ? REQ1 : RESP);
            WAIT0: if (mem_rvalid) state_n = op_split ? REQ1 : RESP;
            REQ1:  if (mem_gnt) state_n = !mem_we ? WAIT1 : RESP;
            WAIT1: if (mem_rvalid) state_n = RESP;
            RESP:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next values of the registered outputs; everything holds unless a transition loads it
    always_comb begin
        n_req   = (state_n == REQ0) || (state_n == REQ1);
        n_we    = mem_we;
        n_addr  = mem_addr;
        n_be    = mem_be;
        n_wdata = mem_wdata;
        n_rdata = rdata;
        n_done  = (state_n == RESP);
        if (accept) begin
            n_we    = !MemRead;
            n_addr  = addr[ADDR_W-1:2];
            n_be    = in_mask[3:0];
            n_wdata = in_wsh[DATA_W-1:0];
        end
        if ((state_n == REQ1) && (state != REQ1)) begin
            n_addr  = mem_addr + WA_W'(1);
            n_be    = op_be1;
            n_wdata = op_wsh_hi;
        end
        if (mem_rvalid && (state == WAIT0) && !op_split)
            n_rdata = extend_load(op_f3, assemble({DATA_W{1'b0}}, mem_rdata, op_off));
        if (mem_rvalid && (state == WAIT1))
            n_rdata = extend_load(op_f3, assemble(mem_rdata, op_word0, op_off));
    end

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
// Bench for load_store_unit: directed and randomized loads/stores against a
// byte-addressed reference memory, served by a memory model with variable latency.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid, MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic        req_ready, stall, done;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [6:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    load_store_unit #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .MemRead(MemRead),
        .MemWrite(MemWrite), .Funct3(Funct3), .addr(addr), .wdata(wdata),
        .req_ready(req_ready), .stall(stall), .done(done), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // memory model state (written only by the responder process)
    logic [31:0] mem_w [128];
    logic        acc_we   [256];
    logic [6:0]  acc_addr [256];
    logic [3:0]  acc_be   [256];
    logic [31:0] acc_wd   [256];
    int          acc_n;
    int          gnt_lat = 0;
    int          rv_lat  = 0;

    // reference model (written only by the stimulus process)
    logic [7:0]  ref_mem [512];

    logic        prev_req;
    logic [6:0]  prev_addr;
    logic [3:0]  prev_be;
    logic [31:0] prev_wd;

    function automatic logic [31:0] init_word(input int i);
        return 32'h9E3779B9 * (i + 1);
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input int a, input logic [2:0] f3);
        logic [31:0] v;
        v = 0;
        for (int i = 0; i < nbytes(f3); i++)
            v = v | (32'(ref_mem[(a + i) % 512]) << (8 * i));
        if (f3 == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (prev_req && !mem_gnt && rst_n)
            check("req_hold", {mem_req, mem_addr, mem_be, mem_wdata},
                  {1'b1, prev_addr, prev_be, prev_wd});
        prev_req  = mem_req;
        prev_addr = mem_addr;
        prev_be   = mem_be;
        prev_wd   = mem_wdata;
    endtask

    task automatic do_op(input bit ld, input bit both, input logic [2:0] f3,
                         input logic [8:0] a, input logic [31:0] wd, output int acc0);
        int          ai, n, lat, exp_lat, g, r;
        bit          split;
        logic [31:0] exp;
        ai    = int'(a);
        n     = nbytes(f3);
        split = ((ai % 4) + n) > 4;
        g     = gnt_lat;
        r     = rv_lat;
        if (ld) exp_lat = split ? 5 + 2*g + 2*r : 3 + g + r;
        else    exp_lat = split ? 3 + 2*g : 2 + g;
        exp = 0;
        if (ld) exp = ref_load(ai, f3);
        else for (int i = 0; i < n; i++) ref_mem[(ai + i) % 512] = wd[8*i +: 8];
        acc0 = acc_n;
        @(negedge clk);
        req_valid = 1'b1;
        MemRead   = ld;
        MemWrite  = !ld || both;
        Funct3    = f3;
        addr      = a;
        wdata     = wd;
        #1;
        check("accept_stall", {req_ready, stall}, 2'b11);
        tick();
        req_valid = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        lat = 1;
        while (!done && lat < 60) begin
            tick();
            lat++;
        end
        if (!done) begin
            check("timeout", 0, 1);
        end else begin
            check("latency", lat, exp_lat);
            if (ld) check("rdata", rdata, exp);
            check("access_count", acc_n - acc0, split ? 2 : 1);
        end
        tick();
        check("done_pulse", {done, req_ready}, 2'b01);
    endtask

    // memory responder: grants after gnt_lat cycles, returns read data rv_lat cycles after the gnt cycle
    initial begin
        bit          rd_pend;
        int          wcnt, rcnt;
        logic [31:0] rd_word;
        for (int i = 0; i < 128; i++) mem_w[i] = init_word(i);
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; acc_n = 0;
        rd_pend = 0; wcnt = 0; rcnt = 0; rd_word = 0;
        forever begin
            @(negedge clk);
            mem_gnt    = 0;
            mem_rvalid = 0;
            if (!rst_n) begin
                rd_pend = 0;
                wcnt    = 0;
            end else if (rd_pend) begin
                if (rcnt == 0) begin
                    mem_rvalid = 1;
                    mem_rdata  = rd_word;
                    rd_pend    = 0;
                end else rcnt--;
            end else if (mem_req) begin
                if (wcnt >= gnt_lat) begin
                    mem_gnt = 1;
                    wcnt    = 0;
                    acc_we[acc_n % 256]   = mem_we;
                    acc_addr[acc_n % 256] = mem_addr;
                    acc_be[acc_n % 256]   = mem_be;
                    acc_wd[acc_n % 256]   = mem_wdata;
                    acc_n++;
                    if (mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_be[b]) mem_w[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
                    end else begin
                        rd_pend = 1;
                        rd_word = mem_w[mem_addr];
                        rcnt    = rv_lat;
                    end
                end else wcnt++;
            end
        end
    end

    initial begin
        int k0;
        bit ld, both;
        logic [2:0]  f3;
        logic [8:0]  a;
        logic [31:0] wd;
        for (int i = 0; i < 128; i++)
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = init_word(i) >> (8 * b);
        prev_req = 0; prev_addr = 0; prev_be = 0; prev_wd = 0;
        rst_n = 0; req_valid = 0; MemRead = 0; MemWrite = 0;
        Funct3 = 0; addr = 0; wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {mem_req, mem_we, mem_addr, mem_be, mem_wdata, done},
              {1'b0, 1'b0, 7'd0, 4'd0, 32'd0, 1'b0});
        check("reset_rdata", rdata, 0);
        check("reset_ready_stall", {req_ready, stall}, 2'b10);
        #1 rst_n = 1;
        tick();

        // request with neither MemRead nor MemWrite is ignored
        @(negedge clk);
        req_valid = 1;
        #1 check("ignore_stall", {req_ready, stall}, 2'b10);
        tick(); tick();
        check("ignore_noreq", {mem_req, done, req_ready}, 3'b001);
        req_valid = 0;

        do_op(0, 0, 3'b010, 9'h010, 32'hDEADBEEF, k0);
        check("sw_acc", {acc_we[k0%256], acc_addr[k0%256], acc_be[k0%256], acc_wd[k0%256]},
              {1'b1, 7'h04, 4'hF, 32'hDEADBEEF});

        do_op(0, 0, 3'b000, 9'h013, 32'h000000A5, k0);
        check("sb_acc", {acc_we[k0%256], acc_addr[k0%256], acc_be[k0%256], acc_wd[k0%256]},
              {1'b1, 7'h04, 4'h8, 32'hA5000000});

        do_op(0, 0, 3'b010, 9'h010, 32'h0000F000, k0);
        do_op(1, 0, 3'b000, 9'h011, 32'h0, k0);
        check("lb_value", rdata, 32'hFFFFFFF0);
        do_op(1, 0, 3'b100, 9'h011, 32'h0, k0);
        check("lbu_value", rdata, 32'h000000F0);

        do_op(0, 0, 3'b010, 9'h004, 32'h44332211, k0);
        do_op(0, 0, 3'b010, 9'h008, 32'h88776655, k0);
        do_op(1, 0, 3'b010, 9'h006, 32'h0, k0);
        check("lw_split_value", rdata, 32'h66554433);
        check("lw_split_be", {acc_we[k0%256], acc_be[k0%256], acc_we[(k0+1)%256], acc_be[(k0+1)%256]},
              {1'b0, 4'hC, 1'b0, 4'h3});

        do_op(0, 0, 3'b001, 9'h1FF, 32'h0000BEEF, k0);
        check("sh_wrap_acc0", {acc_addr[k0%256], acc_be[k0%256], acc_wd[k0%256]},
              {7'h7F, 4'h8, 32'hEF000000});
        check("sh_wrap_acc1", {acc_addr[(k0+1)%256], acc_be[(k0+1)%256], acc_wd[(k0+1)%256]},
              {7'h00, 4'h1, 32'h000000BE});

        // gnt withheld, then reset while waiting for read data
        gnt_lat = 3;
        rv_lat  = 6;
        @(negedge clk);
        req_valid = 1; MemRead = 1; MemWrite = 0; Funct3 = 3'b010; addr = 9'h020;
        tick();
        req_valid = 0; MemRead = 0;
        repeat (5) tick();
        check("wait0_state", {mem_req, stall}, 2'b01);
        #1 rst_n = 0;
        #1;
        check("midreset_outs", {mem_req, done, req_ready, stall, mem_be}, {4'b0010, 4'h0});
        check("midreset_rdata", rdata, 0);
        @(posedge clk);
        #2 rst_n = 1;
        gnt_lat = 0;
        rv_lat  = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("postreset_quiet", {done, mem_req}, 2'b00);
        end
        do_op(1, 0, 3'b010, 9'h010, 32'h0, k0);

        for (int k = 0; k < 60; k++) begin
            ld      = $urandom_range(0, 1);
            both    = ld && ($urandom_range(0, 3) == 0);
            f3      = 3'($urandom);
            a       = 9'($urandom);
            wd      = $urandom;
            gnt_lat = $urandom_range(0, 2);
            rv_lat  = $urandom_range(0, 2);
            do_op(ld, both, f3, a, wd, k0);
        end

        for (int i = 0; i < 128; i++)
            check("final_mem", mem_w[i],
                  {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side initiator for the data memory port. Accepts one load or store per transaction from the MEM stage (RISC-V Funct3 encoding), converts it into one or two aligned word accesses with byte enables over a req/gnt/rvalid handshake, then reassembles and sign- or zero-extends load data. Sits between the MEM stage and the data memory and stalls the pipeline while an access is in flight.

## Interface
- ADDR_W, 9, byte address width; word address is ADDR_W-2 bits
- DATA_W, 32, data width; only 32 is supported

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  MEM stage presents an operation
- MemRead  in  1  load request (from control unit)
- MemWrite  in  1  store request (from control unit)
- Funct3  in  3  instruction bits 14:12: size and signedness
- addr  in  ADDR_W  byte address (ALU result LSBs)
- wdata  in  32  store data, right-aligned
- req_ready  out  1  high only in IDLE
- stall  out  1  freeze the pipeline
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load data; valid when done is high for a load
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W-2  word address
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned write data
- mem_gnt  in  1  memory accepts the current request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data word

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- Accept happens when state is IDLE and req_valid is high and (MemRead or MemWrite) is high. On accept, latch Funct3, addr and wdata, then go to REQ0. MemRead has priority if both reads and writes are asserted. A request with neither asserted is ignored.
- Size comes from Funct3[1:0]: 00 = 1 byte, 01 = 2 bytes, anything else = 4 bytes. off = addr[1:0]. mask = {1, 3, F}[size] << off, giving 8 bits.
- The access is split when off + nbytes > 4: a half at off 3, or a word at off 1, 2 or 3.
- Access 0: mem_addr = addr[ADDR_W-1:2], mem_be = mask[3:0], mem_wdata = (wdata << 8*off)[31:0].
- Access 1 (split only): mem_addr = access 0 address + 1, wrapping modulo 2^(ADDR_W-2). mem_be = mask[7:4], mem_wdata = (wdata << 8*off)[63:32].
- REQ0 and REQ1 drive mem_req=1 with stable address, enables and data until mem_gnt.
  - Store: on gnt go to REQ1 if split, else RESP.
  - Load: on gnt go to WAIT0 or WAIT1 respectively.
- WAIT0 and WAIT1: on mem_rvalid, capture mem_rdata as word 0 or word 1. Then WAIT0 goes to REQ1 if split, else RESP; WAIT1 goes to RESP. mem_rvalid outside the WAIT states is ignored.
- Load assembly: raw = ({word1, word0} >> 8*off)[31:0]; word1 is 0 when there is no split.
- Load extension by Funct3:
  - 000: sign-extend raw[7:0]
  - 001: sign-extend raw[15:0]
  - 100: zero-extend raw[7:0]
  - 101: zero-extend raw[15:0]
  - 010 and all others: raw
- RESP: done=1 for one cycle. rdata is registered on entry to RESP for loads only; it holds its previous value for stores. Next state is IDLE.
- stall = (IDLE and req_valid and (MemRead or MemWrite)) or (state not in {IDLE, RESP}).

## Timing
- Reset state: IDLE. Reset values: mem_req 0, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0, done 0, rdata 0, req_ready 1, stall 0 when there is no request. Reset asserted mid-transaction drops mem_req immediately and discards the transaction.
- All outputs except stall and req_ready are registered.
- Memory contract: one outstanding access; mem_rvalid arrives at least one cycle after the gnt cycle.
- Aligned store, gnt immediate: accept at N, mem_req+gnt at N+1, done at N+2, IDLE at N+3.
- Aligned load, gnt immediate, rvalid 1 cycle later: accept at N, req at N+1, rvalid at N+2, done and rdata at N+3.
- Split load: access 0 and access 1 are strictly sequential, giving a minimum 5 cycles from accept to done.
- Each cycle of delayed gnt or rvalid adds exactly one cycle. mem_req, mem_addr, mem_be and mem_wdata must not change while mem_req=1 and mem_gnt=0.
- Back-to-back: the next accept is possible in the cycle after RESP.

## Test plan
- Aligned SW 0xDEADBEEF to addr 0x010, immediate gnt → one write, mem_addr 0x04, mem_be F, mem_wdata 0xDEADBEEF; done at N+2.
- SB 0x000000A5 to addr 0x013 → mem_be 8, mem_wdata 0xA5000000, mem_addr 0x04.
- LB addr 0x011, memory word 0x0000F000 → rdata 0xFFFFFFF0. LBU from the same address → rdata 0x000000F0.
- Misaligned LW addr 0x006, words 0x44332211 at word 1 and 0x88776655 at word 2 → two reads (be C then 3), rdata 0x66554433, done at N+5.
- SH 0xBEEF to addr 0x1FF → split write: word 0x7F with be 8 and data 0xEF000000, then word 0x00 (wrapped) with be 1 and data 0x000000BE.
- gnt withheld 3 cycles, then rst_n pulsed low during WAIT0 → request signals stable while waiting; after reset mem_req 0, state IDLE, no done pulse, and a following LW completes normally.
